if_id_queue: RTL and testbench

//  Instruction buffer between the fetch stage and the decode stage. Captures each

---
 rtl/if_id_queue_pkg.sv | 22 ++
 rtl/if_queue_mem.sv | 37 +++
 rtl/if_id_queue.sv | 91 +++++++++
 tb/tb_if_id_queue.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// +----------------------------------------------------------------------+
// | if_id_queue_pkg : shared constants and types for the IF/ID queue     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package if_id_queue_pkg;

  localparam int unsigned c_WORD_LEN  = 32;
  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;

  // Bit 1 = push, bit 0 = pop; lets the count update read as a table.
  typedef enum logic [1:0] {
    Q_IDLE = 2'b00,
    Q_POP  = 2'b01,
    Q_PUSH = 2'b10,
    Q_BOTH = 2'b11
  } q_op_e;

endpackage : if_id_queue_pkg

`default_nettype wire

// File: rtl/if_queue_mem.sv
// +----------------------------------------------------------------------+
// | if_queue_mem : DEPTH x WIDTH register array, 1 write / 1 async read  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module if_queue_mem #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : if_queue_mem

`default_nettype wire

// File: rtl/if_id_queue.sv
// +----------------------------------------------------------------------+
// | if_id_queue : fetch-to-decode circular instruction buffer w/ flush   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter  int WORD_LEN = c_WORD_LEN,
  parameter  int DEPTH    = 4,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [WORD_LEN-1:0] if_pc,
  input  logic [WORD_LEN-1:0] if_instruction,
  output logic                if_freeze,
  input  logic                flush,
  input  logic                id_stall,
  output logic                id_valid,
  output logic [WORD_LEN-1:0] id_pc,
  output logic [WORD_LEN-1:0] id_instruction,
  output logic [PTR_W:0]      count
);

  localparam logic [PTR_W:0] c_FULL = DEPTH[PTR_W:0];

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  q_op_e                 w_op;
  logic [2*WORD_LEN-1:0] w_rdata;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);

  // A full queue refuses pushes even when a pop frees a slot this cycle,
  // so if_freeze never depends on the decode stall path.
  assign w_push = if_valid & ~w_full  & ~flush;
  assign w_pop  = ~w_empty & ~id_stall & ~flush;
  assign w_op   = q_op_e'({w_push, w_pop});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case (w_op)
        Q_PUSH:  r_count <= r_count + 1'b1;
        Q_POP:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  if_queue_mem #(
    .WIDTH (2*WORD_LEN),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata ({if_pc, if_instruction}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Empty queue shows decode a NOP bubble rather than stale storage.
  assign if_freeze      = w_full;
  assign id_valid       = ~w_empty;
  assign id_pc          = w_empty ? '0 : w_rdata[2*WORD_LEN-1:WORD_LEN];
  assign id_instruction = w_empty ? WORD_LEN'(c_NOP_INSTR) : w_rdata[WORD_LEN-1:0];
  assign count          = r_count;

endmodule : if_id_queue

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// +----------------------------------------------------------------------+
// | tb_if_id_queue : directed + random bench with a queue reference      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_if_id_queue;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         if_valid;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_instruction;
  logic         if_freeze;
  logic         flush;
  logic         id_stall;
  logic         id_valid;
  logic [W-1:0] id_pc;
  logic [W-1:0] id_instruction;
  logic [2:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference: an unbounded queue of {pc, instr} capped at DEPTH by the rules.
  logic [2*W-1:0] model_q[$];
  logic [W-1:0]   pc_ctr;

  always #5 clk = ~clk;

  if_id_queue #(.WORD_LEN(W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instruction (if_instruction),
    .if_freeze      (if_freeze),
    .flush          (flush),
    .id_stall       (id_stall),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instruction (id_instruction),
    .count          (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n = model_q.size();
    check("count",     64'(count),     64'(n));
    check("count_max", 64'(count <= 3'(DEPTH)), 64'(1));
    check("id_valid",  64'(id_valid),  64'(n != 0));
    check("if_freeze", 64'(if_freeze), 64'(n == DEPTH));
    check("id_pc",     64'(id_pc),     (n != 0) ? 64'(model_q[0][2*W-1:W]) : 64'(0));
    check("id_instr",  64'(id_instruction), (n != 0) ? 64'(model_q[0][W-1:0]) : 64'(0));
  endtask

  // Entered and left at a falling edge; inputs held across the rising edge.
  task automatic cycle(input bit v, input bit fl, input bit st);
    bit do_push, do_pop;
    check_outputs();
    if_valid       = v;
    if_pc          = pc_ctr;
    if_instruction = $urandom;
    flush          = fl;
    id_stall       = st;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
      pc_ctr = 32'h1000 + ($urandom_range(0, 255) << 2);
    end else begin
      do_push = v && (model_q.size() < DEPTH);
      do_pop  = (model_q.size() != 0) && !st;
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back({if_pc, if_instruction});
        pc_ctr = pc_ctr + 4;
      end
    end
    @(negedge clk);
  endtask

  task automatic async_reset_check();
    #2 rst = 1'b0;
    if_valid = 1'b0; flush = 1'b0; id_stall = 1'b0;
    #1;
    model_q.delete();
    pc_ctr = '0;
    check("rst_count",  64'(count),          64'(0));
    check("rst_valid",  64'(id_valid),       64'(0));
    check("rst_instr",  64'(id_instruction), 64'(0));
    check("rst_pc",     64'(id_pc),          64'(0));
    check("rst_freeze", 64'(if_freeze),      64'(0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_instruction = '0;
    flush = 1'b0; id_stall = 1'b0; pc_ctr = '0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b1;

    // Three entries queued, then async reset between edges.
    repeat (3) cycle(1, 0, 1);
    async_reset_check();
    cycle(1, 0, 1);

    // Fill to full under stall, then one held fetch.
    repeat (4) cycle(1, 0, 1);
    // Drain while fetch keeps pushing; pointers wrap.
    repeat (10) cycle(1, 0, 0);

    // Steady push+pop at count 2.
    cycle(0, 1, 0);
    repeat (2) cycle(1, 0, 1);
    repeat (10) cycle(1, 0, 0);

    // Flush with count 3 and a valid fetch in the same cycle.
    cycle(0, 1, 0);
    repeat (3) cycle(1, 0, 1);
    cycle(1, 1, 0);
    cycle(1, 0, 1);
    cycle(0, 0, 1);

    // Empty queue with stall asserted.
    cycle(0, 1, 0);
    repeat (3) cycle(0, 0, 1);

    // Random traffic in phases biased toward fill, drain and mixed.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 120; i++) begin
        bit v, fl, st;
        v  = ($urandom_range(0, 3) != 0);
        fl = ($urandom_range(0, 29) == 0);
        case (ph % 3)
          0:       st = ($urandom_range(0, 3) != 0);
          1:       st = ($urandom_range(0, 3) == 0);
          default: st = $urandom_range(0, 1) != 0;
        endcase
        cycle(v, fl, st);
      end
      if (ph == 2) async_reset_check();
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_if_id_queue

`default_nettype wire
